// File: rtl/fetch_pkg_32.sv
// Shared types and constants for the 32-bit instruction fetch stage.
package fetch_pkg_32;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  // Fetched word together with the sequential address that follows it
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] pc_plus4;
  } fetch_word_t;

endpackage

// File: rtl/fetch_skid_buf_32.sv
// One-entry holding slot for a fetched word that arrives while IF/ID is stalled.
module fetch_skid_buf_32
  import fetch_pkg_32::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  fetch_word_t din,
  output logic        full,
  output fetch_word_t dout
);

  // Clear (redirect) beats load; drain empties the slot after IF/ID takes it
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      full <= 1'b0;
      dout <= '0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit_32.sv
// Instruction fetch stage: PC, imem req/ready/valid handshake, IF/ID register.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit_32
  import fetch_pkg_32::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [INSTR_W-1:0]  imem_addr,
  input  logic                imem_ready,
  input  logic                imem_valid,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [INSTR_W-1:0]  branch_target,
  output logic                if_id_valid,
  output logic [INSTR_W-1:0]  if_id_instr,
  output logic [INSTR_W-1:0]  if_id_pc_plus4,
  output logic [OPCODE_W-1:0] instruction_special
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                fetch_misalign
`endif
);

  fetch_state_t       state_q, state_d;
  logic               kill_q, kill_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] redirect_pc_c;
  logic               req_c, accept_c;
  logic               take_c, park_c, drain_c;
  logic               buf_full;
  fetch_word_t        buf_din, buf_dout;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redirect_pc_c = branch_target;
  assign req_c         = (state_q == S_REQ) && !fetch_misalign;

  // Sticky trap on a redirect to a non-word-aligned target
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_misalign <= 1'b0;
    end else if (branch_taken && (branch_target[1:0] != 2'b00)) begin
      fetch_misalign <= 1'b1;
    end
  end
`else
  assign redirect_pc_c = branch_target & 32'hFFFF_FFFC;
  assign req_c         = (state_q == S_REQ);
`endif

  assign accept_c            = req_c && imem_ready;
  assign imem_req            = req_c && !rst;
  assign imem_addr           = pc_q;
  assign instruction_special = if_id_instr[OPCODE_MSB:OPCODE_LSB];
  assign buf_din             = '{instr: imem_rdata, pc_plus4: pc_q + PC_STEP};

  // Next-state, PC and kill decisions; a redirect overrides everything else
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    pc_d    = pc_q;
    take_c  = 1'b0;
    park_c  = 1'b0;
    drain_c = 1'b0;
    if (branch_taken) begin
      pc_d = redirect_pc_c;
      unique case (state_q)
        S_REQ: begin
          if (accept_c) begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_valid) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d  = 1'b1;
          end
        end
        default: begin
          state_d = S_REQ;
          kill_d  = 1'b0;
        end
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (accept_c) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_valid) begin
            state_d = S_REQ;
            if (kill_q) begin
              kill_d = 1'b0;
            end else if (!if_id_valid || !stall) begin
              take_c = 1'b1;
              pc_d   = pc_q + PC_STEP;
            end else begin
              park_c  = 1'b1;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall && buf_full) begin
            drain_c = 1'b1;
            pc_d    = pc_q + PC_STEP;
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_REQ;
    else     state_q <= state_d;
  end

  // PC and stale-response kill flag
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      kill_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      kill_q <= kill_d;
    end
  end

  // IF/ID register: flush on redirect, load new or buffered word, bubble when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_valid    <= 1'b0;
      if_id_instr    <= NOP_WORD;
      if_id_pc_plus4 <= '0;
    end else if (branch_taken) begin
      if_id_valid    <= 1'b0;
    end else if (take_c) begin
      if_id_valid    <= 1'b1;
      if_id_instr    <= imem_rdata;
      if_id_pc_plus4 <= pc_q + PC_STEP;
    end else if (drain_c) begin
      if_id_valid    <= 1'b1;
      if_id_instr    <= buf_dout.instr;
      if_id_pc_plus4 <= buf_dout.pc_plus4;
    end else if (!stall) begin
      if_id_valid    <= 1'b0;
    end
  end

  fetch_skid_buf_32 u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (park_c),
    .drain (drain_c),
    .clear (branch_taken),
    .din   (buf_din),
    .full  (buf_full),
    .dout  (buf_dout)
  );

endmodule

// File: tb/tb_fetch_unit_32.sv
// Self-checking bench for fetch_unit_32: directed scenarios plus random traffic
// against a transaction-level reference model and a variable-latency memory.
module tb_fetch_unit_32;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_ready, imem_valid, stall, branch_taken, if_id_valid;
  logic [31:0] imem_addr, imem_rdata, branch_target, if_id_instr, if_id_pc_plus4;
  logic [5:0]  instruction_special;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign;
`endif

  always #5 clk = ~clk;

  fetch_unit_32 dut (
    .clk                 (clk),
    .rst                 (rst),
    .imem_req            (imem_req),
    .imem_addr           (imem_addr),
    .imem_ready          (imem_ready),
    .imem_valid          (imem_valid),
    .imem_rdata          (imem_rdata),
    .stall               (stall),
    .branch_taken        (branch_taken),
    .branch_target       (branch_target),
    .if_id_valid         (if_id_valid),
    .if_id_instr         (if_id_instr),
    .if_id_pc_plus4      (if_id_pc_plus4),
    .instruction_special (instruction_special)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misalign      (fetch_misalign)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: fetch pointer, request bookkeeping, parked word, IF/ID
  logic [31:0] m_pc = 32'h0, m_instr = 32'h0, m_p4 = 32'h0, m_park_w = 32'h0, m_park_p4 = 32'h0;
  bit          m_out = 0, m_drop = 0, m_park = 0, m_v = 0, m_trap = 0;

  // Memory environment: one pending read with a countdown
  bit          mem_pend = 0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h8C01_0004;
    if (a == 32'h4) return 32'h0022_1820;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic model_step(input bit r, input bit st, input bit br, input logic [31:0] tg,
                            input bit rdy, input bit vld, input logic [31:0] rd);
    bit issuing, accepted, arrived, got;
    if (r) begin
      m_pc = 32'h0; m_out = 0; m_drop = 0; m_park = 0;
      m_v = 0; m_instr = 32'h0; m_p4 = 32'h0; m_trap = 0;
      return;
    end
    issuing  = !m_out && !m_park && !m_trap;
    accepted = issuing && rdy;
    arrived  = m_out && vld;
    if (br) begin
      if (accepted) begin m_out = 1; m_drop = 1; end
      else if (arrived) begin m_out = 0; m_drop = 0; end
      else if (m_out) m_drop = 1;
      m_park = 0;
      m_v    = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (tg[1:0] != 2'b00) m_trap = 1;
      m_pc = tg;
`else
      m_pc = {tg[31:2], 2'b00};
`endif
      return;
    end
    got = 0;
    if (arrived) begin
      m_out = 0;
      if (m_drop) m_drop = 0;
      else if (!m_v || !st) begin
        m_v = 1; m_instr = rd; m_p4 = m_pc + 32'd4; m_pc = m_pc + 32'd4; got = 1;
      end else begin
        m_park = 1; m_park_w = rd; m_park_p4 = m_pc + 32'd4;
      end
    end else if (m_park && !st) begin
      m_v = 1; m_instr = m_park_w; m_p4 = m_park_p4; m_pc = m_pc + 32'd4;
      m_park = 0; got = 1;
    end
    if (accepted) m_out = 1;
    if (!got && !st) m_v = 0;
  endtask

  // One clock: check registered state, drive inputs, check request outputs, advance model
  task automatic cycle(input bit r, input bit st, input bit br, input logic [31:0] tg,
                       input bit rdy_en, input int lat);
    bit          exp_req, vld, rdy;
    logic [31:0] rd;
    @(negedge clk);
    check("if_id_valid", 32'(if_id_valid), 32'(m_v));
    check("if_id_instr", if_id_instr, m_instr);
    check("if_id_pc_plus4", if_id_pc_plus4, m_p4);
    check("instruction_special", 32'(instruction_special), m_instr >> 26);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("fetch_misalign", 32'(fetch_misalign), 32'(m_trap));
`endif
    vld = mem_pend && (mem_cnt == 0);
    rdy = !mem_pend && rdy_en;
    rd  = vld ? mem_word(mem_addr) : $urandom;
    rst = r; stall = st; branch_taken = br; branch_target = tg;
    imem_valid = vld; imem_ready = rdy; imem_rdata = rd;
    #1;
    exp_req = !r && !m_out && !m_park && !m_trap;
    check("imem_req", 32'(imem_req), 32'(exp_req));
    check("imem_addr", imem_addr, m_pc);
    if (vld) mem_pend = 0;
    else if (mem_pend) mem_cnt--;
    if (exp_req && rdy) begin
      mem_pend = 1; mem_addr = m_pc; mem_cnt = lat - 1;
    end
    model_step(r, st, br, tg, rdy, vld, rd);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] tg;
  bit          ok;

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    imem_ready = 1'b0; imem_valid = 1'b0; imem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(if_id_valid), 32'h0);
    check("reset_special", 32'(instruction_special), 32'h0);
    cycle(1, 0, 0, 32'h0, 1, 1);

    // First fetch with single-cycle memory
    cycle(0, 0, 0, 32'h0, 1, 1);
    check("t1_first_addr", imem_addr, 32'h0);
    cycle(0, 0, 0, 32'h0, 1, 1);
    settle();
    check("t1_instr", if_id_instr, 32'h8C01_0004);
    check("t1_special", 32'(instruction_special), 32'h23);
    check("t1_pc4", if_id_pc_plus4, 32'h4);

    // Stall while the next word returns; it must wait in the holding slot
    repeat (3) cycle(0, 1, 0, 32'h0, 1, 1);
    settle();
    check("t2_hold_instr", if_id_instr, 32'h8C01_0004);
    check("t2_hold_valid", 32'(if_id_valid), 32'h1);
    cycle(0, 0, 0, 32'h0, 1, 1);
    settle();
    check("t2_instr", if_id_instr, 32'h0022_1820);
    check("t2_pc4", if_id_pc_plus4, 32'h8);
    check("t2_addr", imem_addr, 32'h8);

    // Redirect while a slow response is outstanding
    cycle(0, 0, 0, 32'h0, 1, 3);
    cycle(0, 0, 1, 32'h40, 0, 1);
    settle();
    check("t3_flush_valid", 32'(if_id_valid), 32'h0);
    cycle(0, 0, 0, 32'h0, 0, 1);
    cycle(0, 0, 0, 32'h0, 0, 1);
    settle();
    check("t3_drop_valid", 32'(if_id_valid), 32'h0);
    check("t3_addr", imem_addr, 32'h40);
    check("t3_req", 32'(imem_req), 32'h1);

    // PC wraparound at the top of the address space
    cycle(0, 0, 1, 32'hFFFF_FFFC, 0, 1);
    ok = 0;
    for (int i = 0; i < 8 && !ok; i++) begin
      cycle(0, 0, 0, 32'h0, 1, 1);
      if (m_v) ok = 1;
    end
    if (!ok) check("t4_timeout", 32'h0, 32'h1);
    settle();
    check("t4_pc4", if_id_pc_plus4, 32'h0);
    check("t4_addr", imem_addr, 32'h0);
    check("t4_instr", if_id_instr, mem_word(32'hFFFF_FFFC));

    // Reset while waiting; the late response must be ignored
    cycle(0, 0, 0, 32'h0, 1, 2);
    cycle(1, 0, 0, 32'h0, 0, 1);
    cycle(0, 0, 0, 32'h0, 1, 1);
    settle();
    check("t5_valid", 32'(if_id_valid), 32'h0);
    check("t5_addr", imem_addr, 32'h0);

    // Random traffic: stalls, redirects, variable latency, occasional reset
    for (int i = 0; i < 3000; i++) begin
      tg = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      tg[1:0] = 2'b00;
`endif
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 3,
            $urandom_range(0, 19) == 0, tg, $urandom_range(0, 9) < 7,
            int'($urandom_range(1, 3)));
    end

    // Misaligned redirect target
    cycle(0, 0, 1, 32'h0000_0042, 0, 1);
    settle();
`ifdef FETCH_MISALIGN_TRAP_EN
    check("t6_trap", 32'(fetch_misalign), 32'h1);
    check("t6_req", 32'(imem_req), 32'h0);
    repeat (4) cycle(0, 0, 0, 32'h0, 1, 1);
    settle();
    check("t6_req_held", 32'(imem_req), 32'h0);
`else
    check("t6_addr", imem_addr, 32'h40);
`endif
    cycle(0, 0, 0, 32'h0, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
